ring_buffer_mr: RTL and testbench

Parametrised successor to the fixed-rate circular buffer: a multi-rate ring buffer of ROW_SIZE-bit rows. Each transaction writes or reads a variable number of rows (1..PAR_WRITE / 1..PAR_READ), selected per transaction. It has independent valid/ready handshakes on the write and read sides, an occupancy output, programmable almost-full/almost-empty flags and a synchronous flush. It sits between producer and consumer stages of the accelerator datapath, where the two sides run at different lane widths.

---
 rtl/ring_buffer_mr.sv | 156 +++++++++++++++
 tb/tb_ring_buffer_mr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer_mr.sv
// Multi-rate ring buffer of ROW_SIZE-bit rows.
// Each write pushes 1..PAR_WRITE rows and each pop removes 1..PAR_READ rows, chosen per
// transaction. The read side is show-ahead: dout always presents the oldest rows.
// Status flags come only from the occupancy register, so they trail the transaction by one edge.
// DEPTH need not be a power of two. Pointer wrap is done by compare-and-subtract, not by masking.
module ring_buffer_mr #(
    parameter int unsigned ROW_SIZE  = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned PAR_WRITE = 4,
    parameter int unsigned PAR_READ  = 4,
    parameter int unsigned AF_LEVEL  = 28,
    parameter int unsigned AE_LEVEL  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              wr_valid,
    input  logic [$clog2(PAR_WRITE+1)-1:0]    wr_count,
    input  logic [ROW_SIZE*PAR_WRITE-1:0]     din,
    output logic                              wr_ready,
    input  logic                              rd_en,
    input  logic [$clog2(PAR_READ+1)-1:0]     rd_count,
    output logic [ROW_SIZE*PAR_READ-1:0]      dout,
    output logic                              rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty
);

    // Field widths: write count, read count, occupancy, pointer, pointer sum.
    localparam int unsigned WCW = $clog2(PAR_WRITE + 1);
    localparam int unsigned RCW = $clog2(PAR_READ + 1);
    localparam int unsigned OCW = $clog2(DEPTH + 1);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that ptr + n cannot overflow before the wrap compare.
    localparam int unsigned SW  = PW + 1;

    localparam logic [WCW-1:0] MaxWr    = WCW'(PAR_WRITE);
    localparam logic [RCW-1:0] MaxRd    = RCW'(PAR_READ);
    localparam logic [OCW-1:0] DepthOcc = OCW'(DEPTH);
    localparam logic [SW-1:0]  DepthSum = SW'(DEPTH);

    // Return (ptr + n) mod DEPTH. This is valid when ptr < DEPTH and n <= DEPTH.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [SW-1:0] n);
        logic [SW-1:0] sum;
        sum = {1'b0, ptr} + n;
        if (sum >= DepthSum) begin
            sum = sum - DepthSum;
        end
        return sum[PW-1:0];
    endfunction

    // Storage is deliberately not reset. Rows are only visible through occupancy.
    logic [ROW_SIZE-1:0] mem_q [DEPTH];

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [OCW-1:0] occ_q, occ_d;

    logic           wr_legal, rd_legal;
    logic           wr_fire, rd_fire;
    logic [OCW-1:0] wr_len, rd_len;
    logic [OCW-1:0] free_rows;

    logic [PW-1:0]  wr_addr [PAR_WRITE];
    logic [PW-1:0]  rd_addr [PAR_READ];

    // Decode the transaction sizes and both handshakes from the pre-edge occupancy.
    always_comb begin
        wr_len    = OCW'(wr_count);
        rd_len    = OCW'(rd_count);
        free_rows = DepthOcc - occ_q;
        wr_legal  = (wr_count != '0) && (wr_count <= MaxWr);
        rd_legal  = (rd_count != '0) && (rd_count <= MaxRd);
        // Flush masks both sides so that nothing moves in the cycle it clears the buffer.
        wr_ready  = wr_legal && (free_rows >= wr_len) && !flush;
        rd_valid  = rd_legal && (occ_q >= rd_len) && !flush;
        wr_fire   = wr_valid && wr_ready;
        rd_fire   = rd_en && rd_valid;
    end

    // Compute the per-lane array addresses. A transaction may straddle the end of the array.
    always_comb begin
        for (int i = 0; i < int'(PAR_WRITE); i++) begin
            wr_addr[i] = wrap_add(wptr_q, SW'(i));
        end
        for (int i = 0; i < int'(PAR_READ); i++) begin
            rd_addr[i] = wrap_add(rptr_q, SW'(i));
        end
    end

    // Drive the show-ahead read lanes. A lane is zeroed if not requested or holding no stored row.
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(PAR_READ); i++) begin
            if ((RCW'(i) < rd_count) && (OCW'(i) < occ_q)) begin
                dout[i*ROW_SIZE +: ROW_SIZE] = mem_q[rd_addr[i]];
            end
        end
    end

    // Compute next pointers and occupancy. Flush overrides any write or pop in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_fire) begin
                wptr_d = wrap_add(wptr_q, SW'(wr_count));
                occ_d  = occ_d + wr_len;
            end
            if (rd_fire) begin
                rptr_d = wrap_add(rptr_q, SW'(rd_count));
                occ_d  = occ_d - rd_len;
            end
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Row storage. Only the first wr_count lanes of an accepted write are stored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(PAR_WRITE); i++) begin
            if (wr_fire && !rst && (WCW'(i) < wr_count)) begin
                mem_q[wr_addr[i]] <= din[i*ROW_SIZE +: ROW_SIZE];
            end
        end
    end

    // Status flags. These are derived from the occupancy register only, never from the current inputs.
    always_comb begin
        occupancy    = occ_q;
        full         = (occ_q == DepthOcc);
        empty        = (occ_q == '0);
        almost_full  = (32'(occ_q) >= AF_LEVEL);
        almost_empty = (32'(occ_q) <= AE_LEVEL);
    end

endmodule

// File: tb/tb_ring_buffer_mr.sv
// Self-checking bench for ring_buffer_mr.
// Two instances share the stimulus: DEPTH=32 and DEPTH=30, the latter to cover a
// non-power-of-two wrap. Each instance is compared against its own queue model of stored rows.
module tb_ring_buffer_mr;

    localparam int ROW = 8;
    localparam int PW  = 4;
    localparam int PR  = 4;
    localparam int D0  = 32;
    localparam int D1  = 30;
    localparam int AF0 = 28;
    localparam int AF1 = 26;
    localparam int AE  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  wr_count = 3'd0;
    logic [2:0]  rd_count = 3'd0;
    logic [31:0] din = '0;

    logic [1:0]  wr_ready_v, rd_valid_v, full_v, empty_v, af_v, ae_v;
    logic [31:0] dout_v [2];
    logic [5:0]  occ0;
    logic [4:0]  occ1;

    ring_buffer_mr #(
        .ROW_SIZE(ROW), .DEPTH(D0), .PAR_WRITE(PW), .PAR_READ(PR),
        .AF_LEVEL(AF0), .AE_LEVEL(AE)
    ) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_count(wr_count),
        .din(din), .wr_ready(wr_ready_v[0]), .rd_en(rd_en), .rd_count(rd_count),
        .dout(dout_v[0]), .rd_valid(rd_valid_v[0]), .occupancy(occ0), .full(full_v[0]),
        .empty(empty_v[0]), .almost_full(af_v[0]), .almost_empty(ae_v[0])
    );

    ring_buffer_mr #(
        .ROW_SIZE(ROW), .DEPTH(D1), .PAR_WRITE(PW), .PAR_READ(PR),
        .AF_LEVEL(AF1), .AE_LEVEL(AE)
    ) u_dut30 (
        .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_count(wr_count),
        .din(din), .wr_ready(wr_ready_v[1]), .rd_en(rd_en), .rd_count(rd_count),
        .dout(dout_v[1]), .rd_valid(rd_valid_v[1]), .occupancy(occ1), .full(full_v[1]),
        .empty(empty_v[1]), .almost_full(af_v[1]), .almost_empty(ae_v[1])
    );

    always #5 clk = ~clk;

    // Reference model: rows held by each instance, oldest first.
    logic [7:0] mq [2][$];
    bit         wfire [2];
    bit         rfire [2];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output of both instances with what the model predicts for the present inputs.
    task automatic check_outputs();
        int          sz, d, af, wc, rc;
        bit          exp_wr, exp_rd;
        logic [31:0] exp_dout;
        logic [63:0] occ_obs;
        string       p;
        for (int k = 0; k < 2; k++) begin
            sz = mq[k].size();
            d  = (k == 0) ? D0 : D1;
            af = (k == 0) ? AF0 : AF1;
            p  = (k == 0) ? "d32" : "d30";
            wc = int'(wr_count);
            rc = int'(rd_count);
            exp_wr = (wc >= 1) && (wc <= PW) && ((d - sz) >= wc) && !flush;
            exp_rd = (rc >= 1) && (rc <= PR) && (sz >= rc) && !flush;
            exp_dout = '0;
            for (int i = 0; i < PR; i++) begin
                if (i < rc && i < sz) exp_dout[i*8 +: 8] = mq[k][i];
            end
            occ_obs = (k == 0) ? 64'(occ0) : 64'(occ1);
            check_eq({p, ".wr_ready"}, 64'(wr_ready_v[k]), 64'(exp_wr));
            check_eq({p, ".rd_valid"}, 64'(rd_valid_v[k]), 64'(exp_rd));
            check_eq({p, ".dout"}, 64'(dout_v[k]), 64'(exp_dout));
            check_eq({p, ".occupancy"}, occ_obs, 64'(sz));
            check_eq({p, ".full"}, 64'(full_v[k]), 64'(sz == d));
            check_eq({p, ".empty"}, 64'(empty_v[k]), 64'(sz == 0));
            check_eq({p, ".almost_full"}, 64'(af_v[k]), 64'(sz >= af));
            check_eq({p, ".almost_empty"}, 64'(ae_v[k]), 64'(sz <= AE));
            wfire[k] = wr_valid && exp_wr;
            rfire[k] = rd_en && exp_rd;
        end
    endtask

    // Apply one cycle of stimulus, check the combinational view, then retire it into the model.
    task automatic step(input bit f, input bit wv, input int wc, input logic [31:0] wdin,
                        input bit re, input int rc);
        @(negedge clk);
        flush    = f;
        wr_valid = wv;
        wr_count = 3'(wc);
        din      = wdin;
        rd_en    = re;
        rd_count = 3'(rc);
        #1;
        check_outputs();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                mq[k].delete();
            end else begin
                if (rfire[k]) begin
                    for (int i = 0; i < int'(rd_count); i++) void'(mq[k].pop_front());
                end
                if (wfire[k]) begin
                    for (int i = 0; i < int'(wr_count); i++) mq[k].push_back(din[i*8 +: 8]);
                end
            end
        end
    endtask

    function automatic logic [31:0] rows_from(input int base);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(base + i);
        return v;
    endfunction

    task automatic idle();
        step(1'b0, 1'b0, 4, 32'h0, 1'b0, 1);
    endtask

    // Pulse reset between clock edges and check that the outputs clear before the next edge.
    task automatic reset_pulse();
        @(negedge clk);
        flush = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; wr_count = 3'd4; rd_count = 3'd1;
        #1 rst = 1'b1;
        mq[0].delete();
        mq[1].delete();
        #1;
        check_outputs();
        #1 rst = 1'b0;
    endtask

    int seq;
    int rates [3] = '{1, 2, 4};

    initial begin
        // Hold reset with legal idle counts applied, then release it.
        @(negedge clk);
        wr_count = 3'd4;
        rd_count = 3'd1;
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Fill with rows 0x00..0x1F. The extra write must bounce off the full buffer.
        for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 4, rows_from(4 * j), 1'b0, 1);
        step(1'b0, 1'b1, 1, 32'h0000_00AA, 1'b0, 1);
        idle();
        check_eq("fill.occ32", 64'(occ0), 64'd32);

        // Mixed rates starting from full: 3-row writes against pops of 1, 2 and 4 rows.
        seq = 8'h40;
        for (int j = 0; j < 45; j++) begin
            step(1'b0, 1'b1, 3, rows_from(seq), 1'b1, rates[j % 3]);
            seq += 3;
        end
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 4, 32'h0, 1'b1, rates[j % 3]);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1);
        idle();

        // Simultaneous write of 2 rows and pop of 3 rows at occupancy 5.
        step(1'b1, 1'b0, 4, 32'h0, 1'b0, 1);
        step(1'b0, 1'b1, 4, rows_from(8'h80), 1'b0, 1);
        step(1'b0, 1'b1, 1, rows_from(8'h84), 1'b0, 1);
        step(1'b0, 1'b1, 2, rows_from(8'h90), 1'b1, 3);
        idle();
        check_eq("simul.occ4", 64'(occ0), 64'd4);

        // Partial availability: two rows stored, four requested.
        step(1'b1, 1'b0, 4, 32'h0, 1'b0, 1);
        step(1'b0, 1'b1, 2, rows_from(8'hA0), 1'b0, 1);
        step(1'b0, 1'b0, 4, 32'h0, 1'b1, 4);
        idle();
        check_eq("partial.occ2", 64'(occ0), 64'd2);

        // Flush wins over a concurrent write and pop at occupancy 10.
        step(1'b1, 1'b0, 4, 32'h0, 1'b0, 1);
        step(1'b0, 1'b1, 4, rows_from(8'hB0), 1'b0, 1);
        step(1'b0, 1'b1, 4, rows_from(8'hB4), 1'b0, 1);
        step(1'b0, 1'b1, 2, rows_from(8'hB8), 1'b0, 1);
        step(1'b1, 1'b1, 2, rows_from(8'hC0), 1'b1, 1);
        idle();
        check_eq("flush.occ0", 64'(occ0), 64'd0);
        check_eq("flush.empty", 64'(empty_v[0]), 64'd1);

        // Mid-stream asynchronous reset.
        step(1'b0, 1'b1, 4, rows_from(8'hD0), 1'b0, 1);
        step(1'b0, 1'b1, 3, rows_from(8'hD4), 1'b1, 2);
        reset_pulse();
        idle();

        // Randomised traffic. Write pressure drifts by phase to visit both full and empty.
        for (int j = 0; j < 3000; j++) begin
            bit f, wv, re;
            int wc, rc, wbias;
            wbias = ((j / 150) % 2 == 0) ? 80 : 25;
            f  = ($urandom_range(0, 99) == 0);
            wv = ($urandom_range(0, 99) < wbias);
            re = ($urandom_range(0, 99) < 100 - wbias);
            wc = ($urandom_range(0, 15) < 13) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7));
            rc = ($urandom_range(0, 15) < 13) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7));
            step(f, wv, wc, $urandom, re, rc);
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
